cpu_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 16-bit Wishbone-style memory bus.
- Master 0 is the data port: the execute/memory-stage dmem_* signals, including two-beat 32-bit stores.
- Master 1 is the instruction-fetch port.
- Grants the shared slave port to one master at a time and holds the grant for that master's whole cyc window, so a multi-beat access is never split.
- A non-granted master sees no ack, which stalls it.

---
 rtl/cpu_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Two-master / one-slave Wishbone-style arbiter with the grant held for the whole cyc window.
// Optional stb-without-ack watchdog is compiled in with `define BUS_TIMEOUT_EN.
module cpu_bus_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_q;      // 0 = master 0 granted last, 1 = master 1
  logic [1:0] blocked_q;
  logic [1:0] elig;
  logic       tie_pick1;
  logic       timeout_hit;
  logic       ack_fwd;
  wb_req_t    m0_req, m1_req, s_req;

  assign m0_req = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i};
  assign m1_req = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i};

  assign elig      = {m1_cyc_i & ~blocked_q[1], m0_cyc_i & ~blocked_q[0]};
  assign tie_pick1 = (PRIORITY_MODE == 1) ? ~last_q : 1'b0;

  // Slave side follows the registered grant only, so an idle bus reads all zeros.
  always_comb begin
    s_req = '0;
    if (grant_q[0])      s_req = m0_req;
    else if (grant_q[1]) s_req = m1_req;
  end

  assign s_adr_o = s_req.adr;
  assign s_dat_o = s_req.dat;
  assign s_sel_o = s_req.sel;
  assign s_we_o  = s_req.we;
  assign s_stb_o = s_req.stb;
  assign s_cyc_o = s_req.cyc;

  assign ack_fwd  = s_ack_i & s_req.stb;
  assign m0_ack_o = ack_fwd & grant_q[0];
  assign m1_ack_o = ack_fwd & grant_q[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      blocked_q <= 2'b00;
    end else begin
      blocked_q[0] <= m0_cyc_i & (blocked_q[0] | (timeout_hit & grant_q[0]));
      blocked_q[1] <= m1_cyc_i & (blocked_q[1] | (timeout_hit & grant_q[1]));
      case (state_q)
        IDLE: begin
          if ((elig == 2'b11 && tie_pick1) || elig == 2'b10) begin
            state_q <= GRANT1;
            grant_q <= 2'b10;
          end else if (elig[0]) begin
            state_q <= GRANT0;
            grant_q <= 2'b01;
          end
        end
        GRANT0: begin
          if (timeout_hit || !m0_cyc_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        GRANT1: begin
          if (timeout_hit || !m1_cyc_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;

  // Every grant is preceded by an idle cycle, which clears the count on grant change.
  assign timeout_hit = (grant_q != 2'b00) && (to_cnt_q == TO_LIM);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (grant_q == 2'b00 || timeout_hit || s_ack_i) to_cnt_d = '0;
    else if (s_req.stb)                             to_cnt_d = to_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign m0_err_o = timeout_hit & grant_q[0];
  assign m1_err_o = timeout_hit & grant_q[1];
`else
  logic unused_to_lim;
  assign unused_to_lim = ^TO_LIM;
  assign timeout_hit   = 1'b0;
  assign m0_err_o      = 1'b0;
  assign m1_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: a fixed-priority and a round-robin instance share all inputs.
module tb_cpu_bus_arbiter;

  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] m0_adr, m1_adr;
  logic [15:0] m0_dat, m1_dat, s_dat;
  logic [1:0]  m0_sel, m1_sel;
  logic m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;

  logic [15:0] f_m0_dat, f_m1_dat, f_s_dat, r_m0_dat, r_m1_dat, r_s_dat;
  logic f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic [31:0] f_s_adr, r_s_adr;
  logic [1:0]  f_s_sel, r_s_sel, f_grant, r_grant;
  logic f_s_we, f_s_stb, f_s_cyc, r_s_we, r_s_stb, r_s_cyc;

  int total = 0;
  int bad = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(f_m0_dat), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(f_m1_dat), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
    .s_adr_o(f_s_adr), .s_dat_o(f_s_dat), .s_sel_o(f_s_sel), .s_we_o(f_s_we),
    .s_stb_o(f_s_stb), .s_cyc_o(f_s_cyc), .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(f_grant)
  );

  cpu_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(r_m0_dat), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(r_m1_dat), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
    .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_sel_o(r_s_sel), .s_we_o(r_s_we),
    .s_stb_o(r_s_stb), .s_cyc_o(r_s_cyc), .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(r_grant)
  );

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic idle_all;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 2'b00; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 2'b00; m1_adr = '0; m1_dat = '0;
    s_ack = 0; s_dat = '0;
  endtask

  task automatic test_reset;
    idle_all();
    rst = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h55; s_ack = 1; s_dat = 16'hFFFF;
    nxt(); nxt(); mid();
    if (f_grant !== 2'b00) begin bad++; $display("FAIL rst_grant_f got=%b exp=00", f_grant); end total++;
    if (r_grant !== 2'b00) begin bad++; $display("FAIL rst_grant_r got=%b exp=00", r_grant); end total++;
    if ({f_s_cyc, f_s_stb} !== 2'b00) begin bad++; $display("FAIL rst_cyc_stb got=%b exp=00", {f_s_cyc, f_s_stb}); end total++;
    if (f_s_adr !== 32'h0) begin bad++; $display("FAIL rst_s_adr got=%h exp=0", f_s_adr); end total++;
    if ({f_m0_ack, f_m1_ack, f_m0_err, f_m1_err} !== 4'b0) begin
      bad++; $display("FAIL rst_ack_err got=%b exp=0000", {f_m0_ack, f_m1_ack, f_m0_err, f_m1_err}); end total++;
    rst = 0; idle_all(); nxt();
  endtask

  task automatic test_m1_only;
    beat_t b, got;
    m1_adr = 32'hA000_0010; m1_sel = 2'b11; m1_cyc = 1; m1_stb = 1;
    mid();
    if ({f_grant, f_s_stb} !== 3'b000) begin bad++; $display("FAIL m1_pre_grant got=%b exp=000", {f_grant, f_s_stb}); end total++;
    nxt(); mid();
    if (f_grant !== 2'b10) begin bad++; $display("FAIL m1_grant got=%b exp=10", f_grant); end total++;
    if (f_s_adr !== 32'hA000_0010 || f_s_stb !== 1'b1) begin
      bad++; $display("FAIL m1_s_adr got=%h/%b exp=a0000010/1", f_s_adr, f_s_stb); end total++;
    nxt();
    s_ack = 1; s_dat = 16'hBEEF;
    exp_q.push_back('{adr: 32'hA000_0010, dat: 16'h0, sel: 2'b11, we: 1'b0});
    mid();
    if ({f_m1_ack, f_m0_ack} !== 2'b10) begin bad++; $display("FAIL m1_ack got=%b exp=10", {f_m1_ack, f_m0_ack}); end total++;
    if (f_m1_dat !== 16'hBEEF) begin bad++; $display("FAIL m1_rdata got=%h exp=beef", f_m1_dat); end total++;
    got = '{adr: f_s_adr, dat: f_s_dat, sel: f_s_sel, we: f_s_we};
    if (exp_q.size() == 0) begin bad++; $display("FAIL m1_sb got=beat exp=none"); end
    else begin b = exp_q.pop_front(); if (got !== b) begin bad++; $display("FAIL m1_sb got=%h exp=%h", got, b); end end
    total++;
    nxt();
    idle_all();
    mid();
    if (f_s_cyc !== 1'b0 || f_grant !== 2'b10) begin
      bad++; $display("FAIL m1_release got=%b/%b exp=0/10", f_s_cyc, f_grant); end total++;
    nxt(); mid();
    if (f_grant !== 2'b00) begin bad++; $display("FAIL m1_idle got=%b exp=00", f_grant); end total++;
    nxt();
  endtask

  task automatic test_fixed_priority;
    beat_t b, got;
    m0_adr = 32'h200; m0_dat = 16'h1111; m0_sel = 2'b11; m0_we = 1; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'hA000_0020; m1_sel = 2'b11; m1_cyc = 1; m1_stb = 1;
    nxt(); mid();
    if (f_grant !== 2'b01) begin bad++; $display("FAIL fp_grant_f got=%b exp=01", f_grant); end total++;
    if (r_grant !== 2'b01) begin bad++; $display("FAIL fp_grant_r got=%b exp=01", r_grant); end total++;
    if (f_s_adr !== 32'h200) begin bad++; $display("FAIL fp_s_adr got=%h exp=200", f_s_adr); end total++;
    repeat (3) nxt();
    s_ack = 1;
    exp_q.push_back('{adr: 32'h200, dat: 16'h1111, sel: 2'b11, we: 1'b1});
    mid();
    if ({f_m0_ack, f_m1_ack} !== 2'b10) begin bad++; $display("FAIL fp_ack got=%b exp=10", {f_m0_ack, f_m1_ack}); end total++;
    got = '{adr: f_s_adr, dat: f_s_dat, sel: f_s_sel, we: f_s_we};
    if (exp_q.size() == 0) begin bad++; $display("FAIL fp_sb got=beat exp=none"); end
    else begin b = exp_q.pop_front(); if (got !== b) begin bad++; $display("FAIL fp_sb got=%h exp=%h", got, b); end end
    total++;
    nxt();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    nxt(); mid();
    if (f_grant !== 2'b00) begin bad++; $display("FAIL fp_turnaround got=%b exp=00", f_grant); end total++;
    nxt(); mid();
    if (f_grant !== 2'b10 || f_s_adr !== 32'hA000_0020) begin
      bad++; $display("FAIL fp_m1_after got=%b/%h exp=10/a0000020", f_grant, f_s_adr); end total++;
    idle_all(); nxt(); nxt();
  endtask

  task automatic test_round_robin;
    logic [1:0] er;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    nxt();
    idle_all();
    nxt();
    for (int i = 0; i < 3; i++) begin
      er = (i % 2 == 0) ? 2'b10 : 2'b01;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      nxt(); mid();
      if (r_grant !== er) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, r_grant, er); end total++;
      if (f_grant !== 2'b01) begin bad++; $display("FAIL rr_fixed%0d got=%b exp=01", i, f_grant); end total++;
      idle_all();
      nxt();
    end
    nxt();
  endtask

  task automatic test_two_beat;
    beat_t b, got;
    m0_adr = 32'h100; m0_dat = 16'h1234; m0_sel = 2'b11; m0_we = 1; m0_cyc = 1; m0_stb = 1;
    nxt();
    m1_adr = 32'hA000_0030; m1_sel = 2'b11; m1_cyc = 1; m1_stb = 1;
    s_ack = 1;
    exp_q.push_back('{adr: 32'h100, dat: 16'h1234, sel: 2'b11, we: 1'b1});
    mid();
    if ({f_grant, f_m0_ack, f_m1_ack} !== 4'b0110) begin
      bad++; $display("FAIL tb_beat1 got=%b exp=0110", {f_grant, f_m0_ack, f_m1_ack}); end total++;
    got = '{adr: f_s_adr, dat: f_s_dat, sel: f_s_sel, we: f_s_we};
    if (exp_q.size() == 0) begin bad++; $display("FAIL tb_sb1 got=beat exp=none"); end
    else begin b = exp_q.pop_front(); if (got !== b) begin bad++; $display("FAIL tb_sb1 got=%h exp=%h", got, b); end end
    total++;
    nxt();
    m0_stb = 0;
    mid();
    if ({f_m0_ack, f_s_stb, f_grant} !== 4'b0001) begin
      bad++; $display("FAIL tb_stray_ack got=%b exp=0001", {f_m0_ack, f_s_stb, f_grant}); end total++;
    nxt();
    m0_adr = 32'h102; m0_dat = 16'h5678; m0_stb = 1;
    exp_q.push_back('{adr: 32'h102, dat: 16'h5678, sel: 2'b11, we: 1'b1});
    mid();
    if (f_m0_ack !== 1'b1) begin bad++; $display("FAIL tb_beat2 got=%b exp=1", f_m0_ack); end total++;
    got = '{adr: f_s_adr, dat: f_s_dat, sel: f_s_sel, we: f_s_we};
    if (exp_q.size() == 0) begin bad++; $display("FAIL tb_sb2 got=beat exp=none"); end
    else begin b = exp_q.pop_front(); if (got !== b) begin bad++; $display("FAIL tb_sb2 got=%h exp=%h", got, b); end end
    total++;
    nxt();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    mid();
    if (f_s_cyc !== 1'b0 || f_grant !== 2'b01) begin
      bad++; $display("FAIL tb_release got=%b/%b exp=0/01", f_s_cyc, f_grant); end total++;
    nxt(); mid();
    if (f_grant !== 2'b00) begin bad++; $display("FAIL tb_turnaround got=%b exp=00", f_grant); end total++;
    nxt(); mid();
    if (f_grant !== 2'b10 || f_s_adr !== 32'hA000_0030) begin
      bad++; $display("FAIL tb_m1_grant got=%b/%h exp=10/a0000030", f_grant, f_s_adr); end total++;
    nxt();
    s_ack = 1;
    exp_q.push_back('{adr: 32'hA000_0030, dat: 16'h0, sel: 2'b11, we: 1'b0});
    mid();
    if (f_m1_ack !== 1'b1) begin bad++; $display("FAIL tb_m1_ack got=%b exp=1", f_m1_ack); end total++;
    got = '{adr: f_s_adr, dat: f_s_dat, sel: f_s_sel, we: f_s_we};
    if (exp_q.size() == 0) begin bad++; $display("FAIL tb_sb3 got=beat exp=none"); end
    else begin b = exp_q.pop_front(); if (got !== b) begin bad++; $display("FAIL tb_sb3 got=%h exp=%h", got, b); end end
    total++;
    nxt();
    idle_all(); nxt(); nxt();
  endtask

  task automatic test_reset_mid;
    m0_adr = 32'h300; m0_cyc = 1; m0_stb = 1; m0_we = 1;
    nxt(); mid();
    if ({f_grant, f_s_stb} !== 3'b011) begin bad++; $display("FAIL rm_pre got=%b exp=011", {f_grant, f_s_stb}); end total++;
    nxt();
    rst = 1;
    nxt();
    rst = 0; s_ack = 1;
    mid();
    if ({f_grant, f_s_cyc, f_s_stb} !== 4'b0000) begin
      bad++; $display("FAIL rm_drop got=%b exp=0000", {f_grant, f_s_cyc, f_s_stb}); end total++;
    if (f_m0_ack !== 1'b0) begin bad++; $display("FAIL rm_ack got=%b exp=0", f_m0_ack); end total++;
    nxt();
    idle_all(); nxt(); nxt();
  endtask

  task automatic test_timeout;
`ifdef BUS_TIMEOUT_EN
    int hit_at;
    hit_at = -1;
    m0_adr = 32'h400; m0_cyc = 1; m0_stb = 1;
    nxt();
    for (int i = 0; i < 10 && hit_at < 0; i++) begin
      mid();
      if (f_m0_err === 1'b1) hit_at = i;
      else nxt();
    end
    if (hit_at != 4) begin bad++; $display("FAIL to_hit_cycle got=%0d exp=4", hit_at); end total++;
    nxt(); mid();
    if ({f_grant, f_m0_err} !== 3'b000) begin bad++; $display("FAIL to_drop got=%b exp=000", {f_grant, f_m0_err}); end total++;
    nxt(); nxt(); mid();
    if (f_grant !== 2'b00) begin bad++; $display("FAIL to_blocked got=%b exp=00", f_grant); end total++;
    m0_cyc = 0; m0_stb = 0;
    nxt();
    m0_cyc = 1; m0_stb = 1;
    nxt(); mid();
    if (f_grant !== 2'b01) begin bad++; $display("FAIL to_regrant got=%b exp=01", f_grant); end total++;
`else
    m0_adr = 32'h400; m0_cyc = 1; m0_stb = 1;
    nxt();
    repeat (6) nxt();
    mid();
    if ({f_grant, f_m0_err, f_m1_err} !== 4'b0100) begin
      bad++; $display("FAIL noto_hold got=%b exp=0100", {f_grant, f_m0_err, f_m1_err}); end total++;
`endif
    idle_all(); nxt(); nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1;
    nxt();
    test_reset();
    test_m1_only();
    test_fixed_priority();
    test_round_robin();
    test_two_beat();
    test_reset_mid();
    test_timeout();
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
